// File: rtl/systolic_tile_feeder_pkg.sv
// Shared types and geometry for the systolic tile feeder: FSM states,
// flush length and array lane/bus widths.
package systolic_tile_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int unsigned FLUSH_CYCLES = 6;
  localparam int unsigned SA_DIM       = 4;
  localparam int unsigned A_LANE_W     = 8;
  localparam int unsigned B_LANE_W     = 9;
  localparam int unsigned A_BUS_W      = SA_DIM * A_LANE_W;
  localparam int unsigned B_BUS_W      = SA_DIM * B_LANE_W;

endpackage

// File: rtl/systolic_tile_feeder_b_offset_lane.sv
// One B lane: sign-extend an int8 operand to 9 bits and add the input offset,
// wrapping modulo 512.
module feeder_b_offset_lane (
  input  logic [7:0] b_byte_i,
  input  logic [8:0] offset_i,
  output logic [8:0] lane_o
);

  always_comb begin
    lane_o = {b_byte_i[7], b_byte_i} + offset_i;
  end

endmodule

// File: rtl/systolic_tile_feeder.sv
// Tile sequencer for the 4x4 systolic array: reads K A-columns/B-rows, streams
// them with the B offset applied, flushes the skew, then hands off the result.
module systolic_tile_feeder
  import systolic_tile_feeder_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned KW = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [KW-1:0]       cmd_k,
  input  logic [AW-1:0]       cmd_a_base,
  input  logic [AW-1:0]       cmd_b_base,
  input  logic [8:0]          in_offset,
  output logic                a_rd_en,
  output logic [AW-1:0]       a_rd_addr,
  input  logic [A_BUS_W-1:0]  a_rd_data,
  output logic                b_rd_en,
  output logic [AW-1:0]       b_rd_addr,
  input  logic [A_BUS_W-1:0]  b_rd_data,
  output logic                sa_start,
  output logic                sa_vld,
  output logic [A_BUS_W-1:0]  sa_a_bus,
  output logic [B_BUS_W-1:0]  sa_b_bus,
  output logic                res_valid,
  input  logic                res_ready
);

  state_e        state_q, state_d;
  logic [KW-1:0] step_q, step_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] a_base_q, a_base_d;
  logic [AW-1:0] b_base_q, b_base_d;
  logic [8:0]    off_q, off_d;

  logic [B_BUS_W-1:0] lane_sum;
  logic               last_step;
  logic               rd_en;
  logic [AW-1:0]      rd_off;

  for (genvar j = 0; j < SA_DIM; j++) begin : g_lane
    feeder_b_offset_lane u_lane (
      .b_byte_i (b_rd_data[A_BUS_W-1-j*A_LANE_W -: A_LANE_W]),
      .offset_i (off_q),
      .lane_o   (lane_sum[B_BUS_W-1-j*B_LANE_W -: B_LANE_W])
    );
  end

  assign last_step = (step_q == k_q - KW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      k_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      k_q      <= k_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      off_q    <= off_d;
    end
  end

  // step_q counts stream beats in STREAM and flush beats in FLUSH
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    k_d      = k_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    off_d    = off_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          k_d      = cmd_k;
          a_base_d = cmd_a_base;
          b_base_d = cmd_b_base;
          off_d    = in_offset;
          step_d   = '0;
          state_d  = S_CLEAR;
        end
      end
      S_CLEAR: begin
        step_d  = '0;
        state_d = (k_q == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (last_step) begin
          step_d  = '0;
          state_d = S_FLUSH;
        end else begin
          step_d = step_q + KW'(1);
        end
      end
      S_FLUSH: begin
        if (step_q == KW'(FLUSH_CYCLES - 1)) begin
          step_d  = '0;
          state_d = S_DONE;
        end else begin
          step_d = step_q + KW'(1);
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // CLEAR prefetches beat 0; each STREAM beat i prefetches beat i+1
  always_comb begin
    cmd_ready = 1'b0;
    sa_start  = 1'b0;
    sa_vld    = 1'b0;
    sa_a_bus  = '0;
    sa_b_bus  = '0;
    res_valid = 1'b0;
    rd_en     = 1'b0;
    rd_off    = '0;
    unique case (state_q)
      S_IDLE:  cmd_ready = 1'b1;
      S_CLEAR: begin
        sa_start = 1'b1;
        rd_en    = (k_q != '0);
      end
      S_STREAM: begin
        sa_vld   = 1'b1;
        sa_a_bus = a_rd_data;
        sa_b_bus = lane_sum;
        rd_en    = !last_step;
        rd_off   = AW'(step_q + KW'(1));
      end
      S_FLUSH: sa_vld = 1'b1;
      S_DONE:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign a_rd_en   = rd_en;
  assign b_rd_en   = rd_en;
  assign a_rd_addr = rd_en ? a_base_q + rd_off : '0;
  assign b_rd_addr = rd_en ? b_base_q + rd_off : '0;

endmodule

// File: tb/tb_systolic_tile_feeder.sv
// Directed bench for systolic_tile_feeder: table of k=1 offset vectors plus
// hand-written k=4 / handshake / k=0 / reset / back-to-back sequences.
module tb_systolic_tile_feeder;

  localparam int unsigned AW = 12;
  localparam int unsigned KW = 12;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [KW-1:0] cmd_k;
  logic [AW-1:0] cmd_a_base;
  logic [AW-1:0] cmd_b_base;
  logic [8:0]    in_offset;
  logic          a_rd_en;
  logic [AW-1:0] a_rd_addr;
  logic [31:0]   a_rd_data;
  logic          b_rd_en;
  logic [AW-1:0] b_rd_addr;
  logic [31:0]   b_rd_data;
  logic          sa_start;
  logic          sa_vld;
  logic [31:0]   sa_a_bus;
  logic [35:0]   sa_b_bus;
  logic          res_valid;
  logic          res_ready;

  systolic_tile_feeder #(.AW(AW), .KW(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_k      (cmd_k),
    .cmd_a_base (cmd_a_base),
    .cmd_b_base (cmd_b_base),
    .in_offset  (in_offset),
    .a_rd_en    (a_rd_en),
    .a_rd_addr  (a_rd_addr),
    .a_rd_data  (a_rd_data),
    .b_rd_en    (b_rd_en),
    .b_rd_addr  (b_rd_addr),
    .b_rd_data  (b_rd_data),
    .sa_start   (sa_start),
    .sa_vld     (sa_vld),
    .sa_a_bus   (sa_a_bus),
    .sa_b_bus   (sa_b_bus),
    .res_valid  (res_valid),
    .res_ready  (res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffers with one-cycle read latency
  logic [31:0] amem [4096];
  logic [31:0] bmem [4096];
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= amem[a_rd_addr];
    if (b_rd_en) b_rd_data <= bmem[b_rd_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of cycle 1 (CLEAR)
  task automatic start_cmd(input logic [KW-1:0] k, input logic [AW-1:0] ab,
                           input logic [AW-1:0] bb, input logic [8:0] off);
    cmd_k      = k;
    cmd_a_base = ab;
    cmd_b_base = bb;
    in_offset  = off;
    cmd_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] a_base;
    logic [AW-1:0] b_base;
    logic [8:0]    off;
    logic [31:0]   a_data;
    logic [31:0]   b_data;
    logic [35:0]   exp_b;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{12'h000, 12'h000, 9'd0,   32'h01020304, 32'h01010101, {9'd1, 9'd1, 9'd1, 9'd1}};
    vecs[1] = '{12'h123, 12'h456, 9'd128, 32'hDEADBEEF, 32'h807F80FF, {9'd0, 9'd255, 9'd0, 9'd127}};
    vecs[2] = '{12'hFFF, 12'h800, 9'h100, 32'h11223344, 32'hFF00017F, {9'h0FF, 9'h100, 9'h101, 9'h17F}};
    vecs[3] = '{12'h7FF, 12'h001, 9'h0FF, 32'h80808080, 32'h7F7F8001, {9'h17E, 9'h17E, 9'h07F, 9'h100}};
    vecs[4] = '{12'h055, 12'hAAA, 9'h1FF, 32'h00000000, 32'h00FF1020, {9'h1FF, 9'h1FE, 9'h00F, 9'h01F}};

    for (int i = 0; i < 4096; i++) begin
      amem[i] = '0;
      bmem[i] = '0;
    end
    cmd_valid  = 1'b0;
    cmd_k      = '0;
    cmd_a_base = '0;
    cmd_b_base = '0;
    in_offset  = '0;
    res_ready  = 1'b0;
    rst_n      = 1'b0;

    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
    chk("rst_sa_vld",    64'(sa_vld),    64'(1'b0));
    chk("rst_sa_start",  64'(sa_start),  64'(1'b0));
    chk("rst_rd_en",     64'({a_rd_en, b_rd_en}), 64'(2'b00));
    chk("rst_res_valid", 64'(res_valid), 64'(1'b0));
    chk("rst_buses",     64'({sa_a_bus, sa_b_bus[31:0]}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // k=1 tiles driven from the vector table
    for (int v = 0; v < 5; v++) begin
      do_reset();
      amem[vecs[v].a_base] = vecs[v].a_data;
      bmem[vecs[v].b_base] = vecs[v].b_data;
      start_cmd(12'd1, vecs[v].a_base, vecs[v].b_base, vecs[v].off);
      chk("v_c1_start",  64'(sa_start),  64'(1'b1));
      chk("v_c1_rd_en",  64'({a_rd_en, b_rd_en}), 64'(2'b11));
      chk("v_c1_a_addr", 64'(a_rd_addr), 64'(vecs[v].a_base));
      chk("v_c1_b_addr", 64'(b_rd_addr), 64'(vecs[v].b_base));
      chk("v_c1_vld",    64'(sa_vld),    64'(1'b0));
      @(negedge clk);
      chk("v_c2_vld",    64'(sa_vld),    64'(1'b1));
      chk("v_c2_a_bus",  64'(sa_a_bus),  64'(vecs[v].a_data));
      chk("v_c2_b_bus",  64'(sa_b_bus),  64'(vecs[v].exp_b));
      chk("v_c2_rd_en",  64'({a_rd_en, b_rd_en}), 64'(2'b00));
      repeat (6) @(negedge clk);
      chk("v_c8_flush",  64'({sa_vld, res_valid}), 64'(2'b10));
      chk("v_c8_buses",  64'({sa_a_bus, sa_b_bus}), 64'(0));
      @(negedge clk);
      chk("v_c9_res",    64'({sa_vld, res_valid}), 64'(2'b01));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("v_c10_idle",  64'({cmd_ready, res_valid}), 64'(2'b10));
    end

    // k=4 at bases 0x010/0x020, then 5-cycle handshake stall with an ignored k=0 command
    begin
      int vld_cnt;
      vld_cnt = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
        amem[12'h010 + i] = 32'hA0B0C0D0 + 32'(i);
        bmem[12'h020 + i] = 32'h01020304 + 32'(i);
      end
      start_cmd(12'd4, 12'h010, 12'h020, 9'd0);
      for (int c = 1; c <= 12; c++) begin
        if (c > 1) @(negedge clk);
        if (sa_vld) vld_cnt++;
        chk("k4_rd_en",  64'({a_rd_en, b_rd_en}), (c <= 4) ? 64'(2'b11) : 64'(2'b00));
        if (c <= 4) begin
          chk("k4_a_addr", 64'(a_rd_addr), 64'(12'h010 + 12'(c - 1)));
          chk("k4_b_addr", 64'(b_rd_addr), 64'(12'h020 + 12'(c - 1)));
        end
        chk("k4_start",  64'(sa_start),  64'(c == 1));
        chk("k4_vld",    64'(sa_vld),    64'(c >= 2 && c <= 11));
        chk("k4_res",    64'(res_valid), 64'(c == 12));
        if (c >= 2 && c <= 5) begin
          chk("k4_a_bus", 64'(sa_a_bus), 64'(32'hA0B0C0D0 + 32'(c - 2)));
          chk("k4_b_bus", 64'(sa_b_bus), 64'({9'd1, 9'd2, 9'd3, 9'(4 + c - 2)}));
        end
      end
      chk("k4_vld_count", 64'(vld_cnt), 64'(10));
      cmd_k      = '0;
      cmd_a_base = 12'h300;
      cmd_b_base = 12'h301;
      cmd_valid  = 1'b1;
      for (int h = 0; h < 5; h++) begin
        @(negedge clk);
        chk("hs_hold", 64'({res_valid, sa_vld, cmd_ready, sa_start}), 64'(4'b1000));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("hs_release", 64'({res_valid, cmd_ready, sa_start}), 64'(3'b010));
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("k0_clear", 64'({sa_start, sa_vld, a_rd_en, b_rd_en}), 64'(4'b1000));
      @(negedge clk);
      chk("k0_res",   64'({res_valid, sa_vld, a_rd_en, sa_start}), 64'(4'b1000));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("k0_idle",  64'({cmd_ready, res_valid}), 64'(2'b10));
    end

    // Asynchronous abort in the second STREAM cycle of k=8, then back-to-back k=2 tiles
    do_reset();
    start_cmd(12'd8, 12'h040, 12'h050, 9'd3);
    @(negedge clk);
    @(negedge clk);
    chk("ab_streaming", 64'(sa_vld), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("ab_async", 64'({cmd_ready, sa_vld, sa_start, a_rd_en, b_rd_en, res_valid}), 64'(6'b100000));
    chk("ab_buses", 64'({sa_a_bus, sa_b_bus[31:0]}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_k      = 12'd2;
    cmd_a_base = 12'h060;
    cmd_b_base = 12'h070;
    in_offset  = 9'd0;
    cmd_valid  = 1'b1;
    res_ready  = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      chk("bb_start", 64'(sa_start),  64'(c == 1 || c == 12));
      chk("bb_res",   64'(res_valid), 64'(c == 10 || c == 21));
      chk("bb_ready", 64'(cmd_ready), 64'(c == 11 || c == 22));
      chk("bb_rd_en", 64'(a_rd_en),   64'(c == 1 || c == 2 || c == 12 || c == 13));
      if (c == 22) cmd_valid = 1'b0;
    end
    res_ready = 1'b0;
    @(negedge clk);
    chk("bb_final_idle", 64'({cmd_ready, sa_start}), 64'(2'b10));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
